// File: rtl/gate_check_pkg.sv
// gate_check_pkg
// Shared definitions for the gate sweep checker:
//   - MODE_* codes for the logic function under test (6 and 7 are reserved
//     and decode as OR),
//   - state_e, the sweep state machine encoding,
//   - width_of(), a counter-width helper that never returns zero.
package gate_check_pkg;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_XOR  = 3'd2;
    localparam logic [2:0] MODE_NAND = 3'd3;
    localparam logic [2:0] MODE_NOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FIN   = 2'd2
    } state_e;

    // Bits needed to count 0..n-1. The result is never below 1, so a
    // counter for n <= 2 still has a legal width.
    function automatic int unsigned width_of(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/gate_ref.sv
// gate_ref
// Combinational reference model of an N_IN-input gate.
// Ports:
//   mode  in  3     function select (MODE_* codes; 6 and 7 behave as OR)
//   vec   in  N_IN  input vector
//   y     out 1     expected gate output for (mode, vec)
module gate_ref
    import gate_check_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [2:0]      mode,
    input  logic [N_IN-1:0] vec,
    output logic            y
);

    always_comb begin
        y = |vec;
        case (mode)
            MODE_AND:  y = &vec;
            MODE_OR:   y = |vec;
            MODE_XOR:  y = ^vec;
            MODE_NAND: y = ~&vec;
            MODE_NOR:  y = ~|vec;
            MODE_XNOR: y = ~^vec;
            default:   y = |vec;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
// Sweeps every N_IN-bit input vector into an external combinational gate,
// holds each vector for DWELL cycles, and compares the gate output against
// gate_ref on the last cycle of the dwell. Reports pass/fail, the number of
// mismatching vectors and the first mismatching vector.
// Ports:
//   clk            in  1       system clock, rising edge
//   rst_n          in  1       synchronous active-low reset
//   start          in  1       begin a sweep (acted on only in IDLE)
//   mode           in  3       function to check, latched at sweep start
//   dut_y          in  1       output of the gate under test
//   stim           out N_IN    vector driven to the gate under test
//   busy           out 1       high while vectors are being driven
//   done           out 1       one-cycle pulse at the end of a sweep
//   pass           out 1       last completed sweep had no mismatches
//   err_count      out N_IN+1  mismatches in the last/current sweep
//   first_err      out N_IN    first mismatching vector
//   first_err_vld  out 1       first_err holds a real vector
module gate_sweep_checker #(
    parameter int N_IN  = 2,
    parameter int DWELL = 100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      mode,
    input  logic            dut_y,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err,
    output logic            first_err_vld
);

    import gate_check_pkg::*;

    localparam int              CNT_W    = int'(width_of(DWELL));
    localparam int              ERR_W    = N_IN + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic [2:0]        mode_q, mode_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [N_IN-1:0]   first_err_q, first_err_d;
    logic              first_err_vld_q, first_err_vld_d;
    logic              pass_q, pass_d;
    logic              ref_y;

    gate_ref #(
        .N_IN (N_IN)
    ) u_ref (
        .mode (mode_q),
        .vec  (vec_q),
        .y    (ref_y)
    );

    // start comes from a board button, so it is registered before the FSM
    // acts on it. This puts the first driven vector one edge after the edge
    // that sampled start.
    always_comb begin
        start_d         = start;
        state_d         = state_q;
        mode_d          = mode_q;
        vec_d           = vec_q;
        cnt_d           = cnt_q;
        err_count_d     = err_count_q;
        first_err_d     = first_err_q;
        first_err_vld_d = first_err_vld_q;
        pass_d          = pass_q;

        case (state_q)
            IDLE: begin
                if (start_q) begin
                    mode_d          = mode;
                    err_count_d     = '0;
                    first_err_d     = '0;
                    first_err_vld_d = 1'b0;
                    pass_d          = 1'b0;
                    vec_d           = '0;
                    cnt_d           = '0;
                    state_d         = DRIVE;
                end
            end

            DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    if (dut_y != ref_y) begin
                        err_count_d = err_count_q + ERR_W'(1);
                        if (!first_err_vld_q) begin
                            first_err_d     = vec_q;
                            first_err_vld_d = 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        // pass is resolved here so it is already valid in
                        // the cycle where done pulses.
                        pass_d  = (err_count_d == '0);
                        state_d = FIN;
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            FIN: begin
                vec_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            start_q         <= 1'b0;
            mode_q          <= '0;
            vec_q           <= '0;
            cnt_q           <= '0;
            err_count_q     <= '0;
            first_err_q     <= '0;
            first_err_vld_q <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            start_q         <= start_d;
            mode_q          <= mode_d;
            vec_q           <= vec_d;
            cnt_q           <= cnt_d;
            err_count_q     <= err_count_d;
            first_err_q     <= first_err_d;
            first_err_vld_q <= first_err_vld_d;
            pass_q          <= pass_d;
        end
    end

    // stim is forced to zero outside DRIVE so the gate sees a quiet input
    // in IDLE and FIN.
    assign stim          = (state_q == DRIVE) ? vec_q : '0;
    assign busy          = (state_q == DRIVE);
    assign done          = (state_q == FIN);
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err     = first_err_q;
    assign first_err_vld = first_err_vld_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] start_v;
    logic [2:0] mode;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Three checker instances cover the three sizes the sweeps need.
    logic       dut_y2, dut_y3, dut_y4;
    logic [1:0] stim2;  logic [3:0] stim3;  logic [3:0] stim4;
    logic       busy2, busy3, busy4, done2, done3, done4, pass2, pass3, pass4;
    logic [2:0] err2;   logic [3:0] err3;   logic [4:0] err4;
    logic [1:0] ferr2;  logic [2:0] ferr3;  logic [3:0] ferr4;
    logic       fvld2, fvld3, fvld4;
    int         kind2, kind3, kind4;

    gate_sweep_checker #(.N_IN(2), .DWELL(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode), .dut_y(dut_y2),
        .stim(stim2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err(ferr2), .first_err_vld(fvld2));

    gate_sweep_checker #(.N_IN(3), .DWELL(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .mode(mode), .dut_y(dut_y3),
        .stim(stim3[2:0]), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err(ferr3), .first_err_vld(fvld3));
    assign stim3[3] = 1'b0;

    gate_sweep_checker #(.N_IN(4), .DWELL(2)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[4]), .mode(mode), .dut_y(dut_y4),
        .stim(stim4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_err(ferr4), .first_err_vld(fvld4));

    // Independent reference: AND = all ones, OR = nonzero, XOR = odd popcount.
    function automatic logic ref_m(input logic [2:0] md, input logic [7:0] v, input int n);
        logic [8:0] full;
        logic a, o, x;
        full = (9'd1 << n) - 9'd1;
        a = (v == full[7:0]);
        o = (v != 8'd0);
        x = ($countones(v) % 2) == 1;
        case (md)
            3'd0: return a;
            3'd1: return o;
            3'd2: return x;
            3'd3: return !a;
            3'd4: return !o;
            3'd5: return !x;
            default: return o;
        endcase
    endfunction

    // Student gate: kind 0..5 is a correct gate of that function, 8 is stuck at 0.
    function automatic logic gate_m(input int kind, input logic [7:0] v, input int n);
        if (kind == 8) return 1'b0;
        return ref_m(3'(kind), v, n);
    endfunction

    always_comb dut_y2 = gate_m(kind2, 8'(stim2), 2);
    always_comb dut_y3 = gate_m(kind3, 8'(stim3), 3);
    always_comb dut_y4 = gate_m(kind4, 8'(stim4), 4);

    int         sel;
    logic [7:0] stim_s, ferr_s;
    logic [8:0] err_s;
    logic       busy_s, done_s, pass_s, fvld_s;

    always_comb begin
        stim_s = '0; ferr_s = '0; err_s = '0;
        busy_s = 1'b0; done_s = 1'b0; pass_s = 1'b0; fvld_s = 1'b0;
        case (sel)
            2: begin stim_s = 8'(stim2); busy_s = busy2; done_s = done2; pass_s = pass2;
                     err_s = 9'(err2); ferr_s = 8'(ferr2); fvld_s = fvld2; end
            3: begin stim_s = 8'(stim3); busy_s = busy3; done_s = done3; pass_s = pass3;
                     err_s = 9'(err3); ferr_s = 8'(ferr3); fvld_s = fvld3; end
            4: begin stim_s = 8'(stim4); busy_s = busy4; done_s = done4; pass_s = pass4;
                     err_s = 9'(err4); ferr_s = 8'(ferr4); fvld_s = fvld4; end
            default: ;
        endcase
    end

    typedef struct {
        logic [15:0] err;
        logic [15:0] first;
        logic        vld;
        logic        pass;
        int          done_j;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] stim_q[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stim"}, 16'(stim_s), 16'd0);
        chk({tag, "_busy"}, 16'(busy_s), 16'd0);
        chk({tag, "_done"}, 16'(done_s), 16'd0);
        chk({tag, "_pass"}, 16'(pass_s), 16'd0);
        chk({tag, "_err"},  16'(err_s),  16'd0);
        chk({tag, "_ferr"}, 16'(ferr_s), 16'd0);
        chk({tag, "_fvld"}, 16'(fvld_s), 16'd0);
    endtask

    // ev: 0 plain, 1 start pulse + mode change during vector 2,
    //     2 reset during vector 2, 3 start held high through the sweep.
    task automatic run_sweep(input int sel_i, input int n, input int d,
                             input logic [2:0] md, input int kind, input int ev);
        exp_t e;
        int   nv;
        bit   seen;
        logic [7:0] s_exp;
        nv   = 1 << n;
        sel  = sel_i;
        case (sel_i)
            2: kind2 = kind;
            3: kind3 = kind;
            default: kind4 = kind;
        endcase

        e.err = 0; e.first = 0; e.vld = 1'b0;
        for (int v = 0; v < nv; v++) begin
            stim_q.push_back(8'(v));
            if (gate_m(kind, 8'(v), n) !== ref_m(md, 8'(v), n)) begin
                e.err++;
                if (!e.vld) begin e.first = 16'(v); e.vld = 1'b1; end
            end
        end
        e.pass   = (e.err == 0);
        e.done_j = nv * d + 1;
        sb_q.push_back(e);

        mode = md;
        start_v[sel_i] = 1'b1;
        @(posedge clk); #1;
        if (ev != 3) start_v[sel_i] = 1'b0;

        seen = 1'b0;
        for (int j = 1; j <= nv * d + 4 && !seen; j++) begin
            @(posedge clk); #1;
            if (((j - 1) % d) == 0 && j <= nv * d) begin
                s_exp = stim_q.pop_front();
                chk("stim", 16'(stim_s), 16'(s_exp));
                chk("busy", 16'(busy_s), 16'd1);
                chk("done_early", 16'(done_s), 16'd0);
            end
            if (j == 1) chk("err_clear", 16'(err_s), 16'd0);
            if (ev == 1 && j == 2 * d + 2) begin start_v[sel_i] = 1'b1; mode = 3'd1; end
            if (ev == 1 && j == 2 * d + 3) start_v[sel_i] = 1'b0;
            if (ev == 2 && j == 2 * d + 2) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                chk_zero("midrst");
                rst_n = 1'b1;
                void'(sb_q.pop_front());
                stim_q.delete();
                return;
            end
            if (done_s) begin
                seen = 1'b1;
                e = sb_q.pop_front();
                chk("done_edge", 16'(j), 16'(e.done_j));
                chk("err_count", 16'(err_s), e.err);
                chk("first_err", 16'(ferr_s), e.first);
                chk("first_vld", 16'(fvld_s), 16'(e.vld));
                chk("pass", 16'(pass_s), 16'(e.pass));
                chk("fin_busy", 16'(busy_s), 16'd0);
                chk("fin_stim", 16'(stim_s), 16'd0);
            end
        end
        chk("done_seen", 16'(seen), 16'd1);
        stim_q.delete();
        if (!seen) return;

        @(posedge clk); #1;
        chk("done_pulse", 16'(done_s), 16'd0);
        chk("pass_hold", 16'(pass_s), 16'(e.pass));
        chk("busy_idle", 16'(busy_s), 16'd0);
        if (ev == 3) begin
            @(posedge clk); #1;
            chk("held_restart_busy", 16'(busy_s), 16'd1);
            chk("held_restart_stim", 16'(stim_s), 16'd0);
            start_v[sel_i] = 1'b0;
            rst_n = 1'b0;
            @(posedge clk); #1;
            chk_zero("held_rst");
            rst_n = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start_v = '0; mode = '0; sel = 2;
        kind2 = 1; kind3 = 1; kind4 = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 2; s <= 4; s++) begin
            sel = s; #1;
            chk_zero("reset");
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_sweep(2, 2, 4, 3'd1, 1, 0);   // correct OR gate
        run_sweep(2, 2, 4, 3'd0, 1, 0);   // AND checked against an OR gate
        run_sweep(3, 3, 3, 3'd2, 8, 0);   // XOR, output stuck at 0
        run_sweep(2, 2, 4, 3'd3, 3, 1);   // NAND, start/mode disturbed mid-sweep
        run_sweep(2, 2, 4, 3'd3, 8, 2);   // reset during vector 2
        run_sweep(2, 2, 4, 3'd3, 3, 0);   // fresh sweep after that reset
        run_sweep(4, 4, 2, 3'd4, 4, 0);   // correct NOR, 16 vectors
        run_sweep(2, 2, 4, 3'd6, 1, 0);   // reserved mode decodes as OR
        run_sweep(2, 2, 4, 3'd2, 2, 3);   // start held high through FIN

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
